mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single 8-bit external memory bus between the processor core (instruction/data port) and the program loader port. It serializes requests through a fixed-latency access state machine and arbitrates round-robin, with a loader lock for program download. It generates chip-select, read/write and data-drive-enable to the top level; the top level owns the tristate: bus driven by `mem_wdata` when `mem_drive` is high, else high-Z.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width.
- `WAIT_CYCLES`, default 1: extra access cycles per transfer. Legal range is 0..15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU request. Hold high with stable `cpu_we`/`cpu_addr`/`cpu_wdata` until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W; `cpu_wdata` in 8.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read data, valid from `cpu_ack`, held until the next CPU read completes.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: same semantics for the loader port.
- `ldr_lock` in 1: while high, the loader owns the bus exclusively and CPU requests are not granted.
- `mem_cs` out 1: memory select.
- `mem_rw` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W; `mem_wdata` out 8.
- `mem_drive` out 1: top level drives the bus when high.
- `mem_rdata` in 8: bus value as seen when not driving.
- `busy` out 1: state is not IDLE.
- `owner` out 1: 0 = CPU, 1 = loader. Selects the port of the current or most recent transfer.

## Operation
States: IDLE, SETUP, ACCESS, DONE. Counter `wcnt` is 4 bits.

- **IDLE**
  - Samples the requests and picks a winner.
  - Latches the winner's `we`, `addr` and `wdata` into internal registers; sets `owner`; goes to SETUP.
  - No request: stays in IDLE.
- **Arbitration** (evaluated only in IDLE):
  - `ldr_lock`=1: only `ldr_req` is considered.
  - Otherwise, a single requester wins.
  - Both requesting: the port not served last wins. `last` register resets to loader, so the CPU wins the first tie.
- **SETUP**
  - `mem_cs`=1, `mem_addr`/`mem_rw` from the latched values, `mem_drive`=latched `we`.
  - `wcnt` <= WAIT_CYCLES; goes to ACCESS.
- **ACCESS**
  - Same bus outputs as SETUP.
  - If `wcnt`!=0: decrement and stay.
  - If `wcnt`==0:
    - on a read, capture `mem_rdata` into the owner's rdata register;
    - update `last` <= owner;
    - go to DONE.
- **DONE**
  - `mem_cs`=0, `mem_drive`=0 (turnaround cycle).
  - Owner's ack=1 for this cycle only; goes to IDLE.
- **Data and protocol rules**
  - Writes never modify either rdata register.
  - The non-owner port's rdata is untouched.
  - Inputs are latched in IDLE, so changes to req/addr/wdata during a transfer are ignored.
  - A request dropped mid-transfer still completes and still acks.
  - `req` still high in the IDLE cycle after ack counts as a new request.
- **`ldr_lock` edges**
  - Asserted during a CPU transfer: that transfer completes normally; the lock applies from the next IDLE.
  - Deasserted: normal arbitration resumes at the next IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, `wcnt`=0, `last`=loader, `owner`=0.
  - All outputs 0: `cpu_ack`, `ldr_ack`, `mem_cs`, `mem_rw`, `mem_drive`, `busy`, `mem_addr`, `mem_wdata`, `cpu_rdata`, `ldr_rdata`.
  - Reset mid-transfer aborts it with no ack, and `mem_drive` drops in the same cycle.
- Bus outputs are registered, or decoded from state and latched registers only; no combinational path from `*_req` to the `mem_*` outputs.
- Request seen high at the edge ending IDLE cycle N:
  - SETUP is cycle N+1.
  - ACCESS is cycles N+2 .. N+2+WAIT_CYCLES.
  - Read data is sampled at the end of the last ACCESS cycle.
  - ack is high in cycle N+3+WAIT_CYCLES.
  - Latency is WAIT_CYCLES+3; back-to-back throughput is one transfer per WAIT_CYCLES+4 cycles.
- `mem_cs` is high for exactly WAIT_CYCLES+2 cycles per transfer. `mem_addr`, `mem_rw` and `mem_wdata` are stable over the whole window.
- At least one cycle with `mem_cs`=0 and `mem_drive`=0 between any two transfers.
- WAIT_CYCLES=0: ACCESS lasts 1 cycle, latency 3.

## Test plan
- **Reset.** Assert `rst` mid-ACCESS of a write -> `mem_drive`, `mem_cs` and `busy` go to 0 before the next edge. No ack. After release, state is IDLE with all outputs 0.
- **CPU read, WAIT_CYCLES=1.** Memory model returns 0xA5 at address 0x3C; CPU reads 0x3C -> `cpu_ack` 4 cycles after the request; `cpu_rdata`=0xA5; `mem_cs` high for 3 cycles; `mem_drive`=0 throughout; `ldr_rdata` unchanged.
- **Loader write.** Loader writes 0x5A to 0x10 -> `mem_rw`=1 and `mem_drive`=1 for 3 cycles with address 0x10 and data 0x5A; `ldr_ack` pulses once; a subsequent CPU read of 0x10 returns 0x5A.
- **Round-robin.** Both ports hold `req` continuously for 4 transfers -> grant order CPU, loader, CPU, loader; idle gap with `mem_cs`=0 between each; exactly one ack per transfer.
- **Lock.** Assert `ldr_lock` while a CPU transfer is in ACCESS, with both ports requesting -> CPU transfer completes and acks; next 3 grants all go to the loader; `cpu_ack` stays 0 until the lock drops, then the CPU is granted next.
- **WAIT_CYCLES=0 and 15.** Single read at each setting -> latency 3 and 18 cycles respectively; ack width is 1 cycle in both.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 8-bit external memory bus between the CPU and loader ports.
// Each transfer runs a fixed-latency IDLE/SETUP/ACCESS/DONE sequence; ldr_lock grants the loader exclusively.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
  output logic [7:0]        ldr_rdata,
  input  logic              ldr_lock,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_drive,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        ldr_rdata_q, ldr_rdata_d;
  logic              grant_any, grant_ldr;

  // On a tie the port not served last wins; last_q resets to loader so the CPU wins first.
  always_comb begin
    grant_any = 1'b0;
    grant_ldr = 1'b0;
    if (ldr_lock) begin
      grant_any = ldr_req;
      grant_ldr = 1'b1;
    end else if (cpu_req && ldr_req) begin
      grant_any = 1'b1;
      grant_ldr = ~last_q;
    end else if (cpu_req) begin
      grant_any = 1'b1;
    end else if (ldr_req) begin
      grant_any = 1'b1;
      grant_ldr = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          owner_d = grant_ldr;
          we_d    = grant_ldr ? ldr_we    : cpu_we;
          addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
          wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
          state_d = StSetup;
        end
      end
      StSetup: begin
        wcnt_d  = WaitInit;
        state_d = StAccess;
      end
      StAccess: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q) ldr_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          last_d  = owner_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= 4'd0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      cpu_rdata_q <= 8'd0;
      ldr_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Bus outputs decode from state and latched registers only, so reset drops them at once.
  assign mem_cs    = (state_q == StSetup) || (state_q == StAccess);
  assign mem_rw    = mem_cs & we_q;
  assign mem_drive = mem_cs & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;
  assign cpu_ack   = (state_q == StDone) && !owner_q;
  assign ldr_ack   = (state_q == StDone) && owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected bus windows and acks,
// a negedge monitor pops and compares them; extra instances cover WAIT_CYCLES of 0 and 15.
module tb_mem_arbiter;

  logic       clk, rst;
  logic       cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack, ldr_lock;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ldr_addr, ldr_wdata, ldr_rdata;
  logic       mem_cs, mem_rw, mem_drive, busy, owner;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  // Signals for the WAIT_CYCLES=0 (index 0) and WAIT_CYCLES=15 (index 1) instances.
  logic [1:0] xs_req, xs_ack, xs_lack, xs_cs, xs_rw, xs_drive, xs_busy, xs_owner;
  logic [7:0] xs_rdata [2];
  logic [7:0] xs_lrdata [2];
  logic [7:0] xs_addr [2];
  logic [7:0] xs_wdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {bit own; bit we; logic [7:0] addr; logic [7:0] wdata; int len;} txn_t;
  typedef struct {logic [7:0] rdata; logic [7:0] other; int cyc;} ack_t;
  txn_t txq[$];
  ack_t cq[$];
  ack_t lq[$];

  mem_arbiter #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_lock(ldr_lock),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_drive(mem_drive), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .cpu_req(xs_req[0]), .cpu_we(1'b0), .cpu_addr(8'h01), .cpu_wdata(8'h00),
    .cpu_ack(xs_ack[0]), .cpu_rdata(xs_rdata[0]),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(8'h00), .ldr_wdata(8'h00),
    .ldr_ack(xs_lack[0]), .ldr_rdata(xs_lrdata[0]), .ldr_lock(1'b0),
    .mem_cs(xs_cs[0]), .mem_rw(xs_rw[0]), .mem_addr(xs_addr[0]), .mem_wdata(xs_wdata[0]),
    .mem_drive(xs_drive[0]), .mem_rdata(8'h5C), .busy(xs_busy[0]), .owner(xs_owner[0])
  );

  mem_arbiter #(.ADDR_W(8), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst),
    .cpu_req(xs_req[1]), .cpu_we(1'b0), .cpu_addr(8'h02), .cpu_wdata(8'h00),
    .cpu_ack(xs_ack[1]), .cpu_rdata(xs_rdata[1]),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(8'h00), .ldr_wdata(8'h00),
    .ldr_ack(xs_lack[1]), .ldr_rdata(xs_lrdata[1]), .ldr_lock(1'b0),
    .mem_cs(xs_cs[1]), .mem_rw(xs_rw[1]), .mem_addr(xs_addr[1]), .mem_wdata(xs_wdata[1]),
    .mem_drive(xs_drive[1]), .mem_rdata(8'h5C), .busy(xs_busy[1]), .owner(xs_owner[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Memory model: preset contents while reset is held, otherwise accept driven writes.
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h3C] <= 8'hA5;
      mem[8'h20] <= 8'h96;
      mem[8'h40] <= 8'hC3;
    end else if (mem_cs && mem_drive) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void exp_txn(input bit own, input bit we, input logic [7:0] a,
                                  input logic [7:0] d, input int len);
    txn_t t;
    t.own = own; t.we = we; t.addr = a; t.wdata = d; t.len = len;
    txq.push_back(t);
  endfunction

  function automatic void exp_ack(input bit ldr, input logic [7:0] rd, input logic [7:0] oth,
                                  input int c);
    ack_t a;
    a.rdata = rd; a.other = oth; a.cyc = c;
    if (ldr) lq.push_back(a);
    else     cq.push_back(a);
  endfunction

  // Monitor: one bus window per cs pulse, one ack entry per ack pulse.
  txn_t cur;
  bit   have_cur = 0;
  bit   cs_prev = 0;
  bit   stable;
  int   cs_len;
  always @(negedge clk) begin
    ack_t a;
    if (mem_cs && !cs_prev) begin
      checks++;
      if (txq.size() == 0) begin
        errors++;
        have_cur = 0;
        $display("FAIL bus_window: unexpected transfer at addr %0h (cycle %0d)", mem_addr, cyc);
      end else begin
        cur = txq.pop_front();
        have_cur = 1;
        check("owner", owner, cur.own);
        check("mem_rw", mem_rw, cur.we);
        check("mem_drive", mem_drive, cur.we);
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wdata", mem_wdata, cur.wdata);
        cs_len = 1;
        stable = 1;
      end
    end else if (mem_cs) begin
      cs_len++;
      if (mem_addr !== cur.addr || mem_rw !== cur.we || mem_wdata !== cur.wdata ||
          mem_drive !== cur.we) stable = 0;
    end else if (cs_prev && have_cur) begin
      check("cs_len", cs_len, cur.len);
      check("bus_stable", stable, 1);
      check("gap_drive", mem_drive, 0);
    end
    cs_prev = mem_cs;
    if (cpu_ack) begin
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL cpu_ack: unexpected ack (cycle %0d)", cyc);
      end else begin
        a = cq.pop_front();
        check("cpu_rdata", cpu_rdata, a.rdata);
        check("ldr_rdata_kept", ldr_rdata, a.other);
        check("ldr_ack_excl", ldr_ack, 0);
        if (a.cyc >= 0) check("cpu_latency", cyc, a.cyc);
      end
    end
    if (ldr_ack) begin
      checks++;
      if (lq.size() == 0) begin
        errors++;
        $display("FAIL ldr_ack: unexpected ack (cycle %0d)", cyc);
      end else begin
        a = lq.pop_front();
        check("ldr_rdata", ldr_rdata, a.rdata);
        check("cpu_rdata_kept", cpu_rdata, a.other);
        if (a.cyc >= 0) check("ldr_latency", cyc, a.cyc);
      end
    end
  end

  task automatic wait_ack(input bit ldr);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ldr ? ldr_ack : cpu_ack) && n < 60);
    checks++;
    if (!(ldr ? ldr_ack : cpu_ack)) begin
      errors++;
      $display("FAIL wait_ack: port %0d no ack within 60 cycles", ldr);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {cpu_ack, ldr_ack, mem_cs, mem_rw, mem_drive, busy, owner, mem_addr, mem_wdata,
                 cpu_rdata, ldr_rdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ldr_lock = 1'b0; xs_req = 2'b00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_idle("in_reset");
    rst = 1'b0;
    @(posedge clk);
    #1 check_idle("after_reset");

    // Reset in the middle of a CPU write: aborted window is 2 cycles, no ack.
    cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'hEE; cpu_req = 1'b1;
    exp_txn(0, 1, 8'h50, 8'hEE, 2);
    @(posedge clk);
    @(posedge clk);
    #1 check("drive_before_rst", mem_drive, 1);
    #6 rst = 1'b1;
    #1 check("abort_outputs", {mem_drive, mem_cs, busy, cpu_ack}, 0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle("after_abort");

    // CPU read of 0x3C returns 0xA5 with latency 4.
    @(posedge clk);
    #1 cpu_we = 1'b0; cpu_addr = 8'h3C; cpu_wdata = 8'h00; cpu_req = 1'b1;
    exp_txn(0, 0, 8'h3C, 8'h00, 3);
    exp_ack(0, 8'hA5, 8'h00, cyc + 4);
    wait_ack(0);
    cpu_req = 1'b0;

    // Loader write 0x5A to 0x10, then CPU reads it back.
    @(posedge clk);
    #1 ldr_we = 1'b1; ldr_addr = 8'h10; ldr_wdata = 8'h5A; ldr_req = 1'b1;
    exp_txn(1, 1, 8'h10, 8'h5A, 3);
    exp_ack(1, 8'h00, 8'hA5, cyc + 4);
    wait_ack(1);
    ldr_req = 1'b0;
    @(posedge clk);
    #1 cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    exp_txn(0, 0, 8'h10, 8'h00, 3);
    exp_ack(0, 8'h5A, 8'h00, cyc + 4);
    wait_ack(0);
    cpu_req = 1'b0;

    // Round-robin from a fresh reset: CPU, loader, CPU, loader.
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 cpu_we = 1'b0; cpu_addr = 8'h20; cpu_wdata = 8'h00; cpu_req = 1'b1;
    ldr_we = 1'b1; ldr_addr = 8'h30; ldr_wdata = 8'h77; ldr_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_txn(0, 0, 8'h20, 8'h00, 3);
      exp_txn(1, 1, 8'h30, 8'h77, 3);
      exp_ack(0, 8'h96, 8'h00, -1);
      exp_ack(1, 8'h00, 8'h96, -1);
    end
    wait_ack(0); wait_ack(1); wait_ack(0); wait_ack(1);
    cpu_req = 1'b0; ldr_req = 1'b0;

    // Lock raised during a CPU access: CPU finishes, loader gets 3 grants, then CPU again.
    @(posedge clk);
    #1 cpu_req = 1'b1;
    ldr_we = 1'b0; ldr_addr = 8'h40; ldr_wdata = 8'h00; ldr_req = 1'b1;
    exp_txn(0, 0, 8'h20, 8'h00, 3);
    exp_ack(0, 8'h96, 8'h00, -1);
    for (int i = 0; i < 3; i++) begin
      exp_txn(1, 0, 8'h40, 8'h00, 3);
      exp_ack(1, 8'hC3, 8'h96, -1);
    end
    exp_txn(0, 0, 8'h20, 8'h00, 3);
    exp_ack(0, 8'h96, 8'hC3, -1);
    @(posedge clk);
    @(posedge clk);
    #1 ldr_lock = 1'b1;
    wait_ack(0);
    wait_ack(1); wait_ack(1); wait_ack(1);
    ldr_lock = 1'b0;
    wait_ack(0);
    cpu_req = 1'b0; ldr_req = 1'b0;

    // Latency 3 and 18 for WAIT_CYCLES 0 and 15, with one-cycle acks.
    for (int i = 0; i < 2; i++) begin
      int t0;
      int w;
      @(posedge clk);
      #1 xs_req[i] = 1'b1;
      t0 = cyc;
      w = 0;
      while (!xs_ack[i] && w < 40) begin
        @(posedge clk);
        #1 w++;
      end
      check(i == 0 ? "latency_w0" : "latency_w15", cyc - t0, i == 0 ? 3 : 18);
      check(i == 0 ? "rdata_w0" : "rdata_w15", xs_rdata[i], 8'h5C);
      xs_req[i] = 1'b0;
      @(posedge clk);
      #1 check(i == 0 ? "ack_width_w0" : "ack_width_w15", xs_ack[i], 0);
    end

    repeat (3) @(posedge clk);
    check("pending_txn", txq.size(), 0);
    check("pending_cpu_ack", cq.size(), 0);
    check("pending_ldr_ack", lq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
